// File: rtl/way_hit_encoder.sv
// way_hit_encoder: two-stage ready/valid priority encoder for way-hit vectors with miss/multi-hit statistics
module way_hit_encoder #(
    parameter int WAYS = 8,
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_W = 16,
    localparam int IW = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WAYS-1:0]  in_hits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW-1:0]    out_way,
    output logic             out_hit,
    output logic             out_multi,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] multi_cnt
);
    logic            s1_valid;
    logic [WAYS-1:0] s1_hits;
    logic            s1_adv;
    logic            s2_adv;
    logic            out_xfer;
    logic [IW-1:0]   enc_way;
    logic            enc_hit;
    logic            enc_multi;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign out_xfer = out_valid && out_ready;

    // scan every way; a second hit flags multi, the winner follows the priority direction
    always_comb begin
        enc_way   = '0;
        enc_hit   = 1'b0;
        enc_multi = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (s1_hits[i]) begin
                enc_multi = enc_multi | enc_hit;
                enc_way   = (MSB_FIRST || !enc_hit) ? IW'(i) : enc_way;
                enc_hit   = 1'b1;
            end
        end
    end

    // stage 1 captures the raw vector whenever it may advance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            s1_hits  <= in_hits;
        end
    end

    // stage 2 holds the encoded result stable until the consumer takes it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_way   <= '0;
            out_hit   <= 1'b0;
            out_multi <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_way   <= enc_way;
                out_hit   <= enc_hit;
                out_multi <= enc_multi;
            end
        end
    end

    // saturating statistics counted on delivered results; clear beats increment
    always_ff @(posedge clk) begin
        if (!rst_n || clr_stats) begin
            miss_cnt  <= '0;
            multi_cnt <= '0;
        end else if (out_xfer) begin
            if (!out_hit && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            if (out_multi && multi_cnt != '1) multi_cnt <= multi_cnt + 1'b1;
        end
    end
endmodule

// File: doc/way_hit_encoder.md
WAY_HIT_ENCODER -- requirements
Module: way_hit_encoder

Interface
- REQ-001 Parameter WAYS, default 8: width of the per-way hit vector; legal range 2..64.
- REQ-002 Parameter MSB_FIRST, default 0: 0 = lowest set index wins, 1 = highest set index wins.
- REQ-003 Parameter CNT_W, default 16: width of each statistics counter.
- REQ-004 Parameter IW is derived as $clog2(WAYS) and SHALL NOT be overridden.
- REQ-005 Port clk, input, 1: the single clock; all state updates on the rising edge.
- REQ-006 Port rst_n, input, 1: synchronous, active-low reset.
- REQ-007 Port in_valid, input, 1: hit vector on in_hits is valid.
- REQ-008 Port in_ready, output, 1: block accepts in_hits this cycle.
- REQ-009 Port in_hits, input, WAYS: one bit per way, 1 = tag match.
- REQ-010 Port out_valid, output, 1: result on the out_* ports is valid.
- REQ-011 Port out_ready, input, 1: consumer accepts the result.
- REQ-012 Port out_way, output, IW: index of the selected way.
- REQ-013 Port out_hit, output, 1: at least one bit of in_hits was set.
- REQ-014 Port out_multi, output, 1: two or more bits of in_hits were set.
- REQ-015 Port clr_stats, input, 1: synchronous clear of both counters.
- REQ-016 Port miss_cnt, output, CNT_W: count of delivered results with out_hit=0.
- REQ-017 Port multi_cnt, output, CNT_W: count of delivered results with out_multi=1.

Function
- REQ-018 Two pipeline stages: S1 registers in_hits; S2 registers the encoded result (out_way, out_hit, out_multi).
- REQ-019 An input transfer occurs when in_valid and in_ready are both 1; an output transfer occurs when out_valid and out_ready are both 1.
- REQ-020 S2 advance: s2_adv = !out_valid || out_ready.
- REQ-021 S1 advance: s1_adv = !s1_valid || s2_adv; in_ready = s1_adv, driven combinationally with no dependence on in_valid.
- REQ-022 Bubbles collapse: an empty stage accepts new data even while the downstream stage is stalled.
- REQ-023 Latency is 2 cycles: a vector transferred at edge N is presented at out_* after edge N+1 when out_ready stays 1.
- REQ-024 Throughput is one result per cycle while out_ready=1.
- REQ-025 While stalled (out_valid=1, out_ready=0), out_* SHALL hold stable; no data is lost or duplicated.
- REQ-026 out_way selection with MSB_FIRST=0: index of the lowest set bit.
- REQ-027 out_way selection with MSB_FIRST=1: index of the highest set bit.
- REQ-028 Zero-hit vector: out_way=0, out_hit=0, out_multi=0.
- REQ-029 out_multi is 1 exactly when popcount(in_hits) >= 2; out_way still follows REQ-026/REQ-027.
- REQ-030 Counters update only on an output transfer; each saturates at 2^CNT_W-1 and never wraps.
- REQ-031 clr_stats=1 sets both counters to 0 on the next edge; clr_stats wins over a simultaneous increment.
- REQ-032 Results leave in the same order their vectors were accepted.

Reset
- REQ-033 While rst_n=0 at an edge: S1 and S2 valid bits clear; out_valid=0; out_way=0; out_hit=0; out_multi=0; miss_cnt=0; multi_cnt=0.
- REQ-034 in_ready is 1 in the first cycle after reset is released.
- REQ-035 Reset asserted mid-transfer discards all in-flight data; no output transfer completes in the reset cycle.

Verification
- REQ-036 WAYS=8, MSB_FIRST=0, in_hits=8'b0010_1000, out_ready=1 -> 2 cycles later: out_way=3, out_hit=1, out_multi=1, multi_cnt=1.
- REQ-037 WAYS=8, MSB_FIRST=1, same vector -> out_way=5, out_multi=1; in_hits=8'h00 -> out_hit=0, out_way=0, miss_cnt increments by 1.
- REQ-038 Back-to-back stream of vectors 8'h01,8'h02,8'h04,8'h80 with out_ready held 0 for 3 cycles mid-stream -> out_way sequence 0,1,2,7 in order; in_ready=0 only while both stages are full; out_* held stable while stalled.
- REQ-039 CNT_W=2, five delivered multi-hit results -> multi_cnt reads 1,2,3,3,3; clr_stats asserted with a sixth delivery -> multi_cnt=0.
- REQ-040 WAYS=64, MSB_FIRST=0, single hot bit at index 63 -> out_way=63 (IW=6); all-ones vector -> out_way=0, out_multi=1.
- REQ-041 rst_n driven to 0 for one cycle with both stages full -> next cycle out_valid=0, both counters 0, in_ready=1.
